// File: rtl/fdiv_scoreboard_pkg.sv
// Shared FPU definitions for the div/sqrt writeback scoreboard: FSM state
// encoding, register-address width and the operand-match helper.
package fdiv_scoreboard_pkg;

  localparam int unsigned FREG_ADDR_W = 5;

  typedef logic [FREG_ADDR_W-1:0] freg_addr_t;

  // IDLE: no div/sqrt outstanding.
  // BUSY: divider is computing; its destination is tracked in PendRd.
  // HOLD: result finished while writeback owned the port; waiting for a free slot.
  typedef enum logic [1:0] {
    FDIV_IDLE = 2'd0,
    FDIV_BUSY = 2'd1,
    FDIV_HOLD = 2'd2
  } fdiv_state_e;

  // True when an enabled register reference targets the tracked destination.
  function automatic logic addr_hit(input logic en, input freg_addr_t a, input freg_addr_t b);
    return en & (a == b);
  endfunction

endpackage

// File: rtl/fdiv_scoreboard_if.sv
// Decode/execute/writeback signals exchanged between the FP pipeline and the
// div/sqrt scoreboard. The pipeline side drives through 'master', the
// scoreboard consumes through 'slave'.
interface fdiv_scoreboard_if;
  import fdiv_scoreboard_pkg::*;

  freg_addr_t Adr1D;
  freg_addr_t Adr2D;
  freg_addr_t Adr3D;
  logic       XEnD;
  logic       YEnD;
  logic       ZEnD;
  logic       FRegWriteD;
  freg_addr_t RdD;
  logic       DivStartD;
  logic       DivStartE;
  freg_addr_t RdE;
  logic       FlushE;
  logic       DivDone;
  logic       FRegWriteW;

  logic       FPUStallD;
  logic       DivWriteW;
  freg_addr_t DivRdW;
  logic       DivResSel;

  modport master (
    output Adr1D, Adr2D, Adr3D, XEnD, YEnD, ZEnD, FRegWriteD, RdD,
    output DivStartD, DivStartE, RdE, FlushE, DivDone, FRegWriteW,
    input  FPUStallD, DivWriteW, DivRdW, DivResSel
  );

  modport slave (
    input  Adr1D, Adr2D, Adr3D, XEnD, YEnD, ZEnD, FRegWriteD, RdD,
    input  DivStartD, DivStartE, RdE, FlushE, DivDone, FRegWriteW,
    output FPUStallD, DivWriteW, DivRdW, DivResSel
  );

endinterface

// File: rtl/fdiv_scoreboard.sv
// Scoreboard for the multi-cycle FP div/sqrt unit. Tracks the one in-flight
// destination register, stalls decode on RAW/WAW/structural hazards against
// it, and arbitrates the FP register-file write port with the pipeline
// writeback stage (writeback always wins; a blocked result is held).
module fdiv_scoreboard
  import fdiv_scoreboard_pkg::*;
(
  input logic               clk,
  input logic               reset,
  fdiv_scoreboard_if.slave  sb
);

  fdiv_state_e state_q;
  freg_addr_t  pend_rd_q;

  logic busy_s;
  logic raw_s;
  logic waw_s;
  logic struct_s;
  logic div_write_s;

  // FSM and pending-destination register; reset abandons any in-flight or held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FDIV_IDLE;
      pend_rd_q <= '0;
    end else begin
      case (state_q)
        FDIV_IDLE: begin
          // A flushed issue never becomes visible to the scoreboard.
          if (sb.DivStartE & ~sb.FlushE) begin
            state_q   <= FDIV_BUSY;
            pend_rd_q <= sb.RdE;
          end
        end
        FDIV_BUSY: begin
          if (sb.DivDone) begin
            state_q <= sb.FRegWriteW ? FDIV_HOLD : FDIV_IDLE;
          end
        end
        FDIV_HOLD: begin
          // DivDone here is a protocol violation and is ignored.
          if (!sb.FRegWriteW) begin
            state_q <= FDIV_IDLE;
          end
        end
        default: begin
          state_q <= FDIV_IDLE;
        end
      endcase
    end
  end

  // Hazard detection and write-port arbitration, evaluated in the same cycle.
  always_comb begin
    busy_s   = (state_q != FDIV_IDLE);
    raw_s    = busy_s & (addr_hit(sb.XEnD, sb.Adr1D, pend_rd_q) |
                         addr_hit(sb.YEnD, sb.Adr2D, pend_rd_q) |
                         addr_hit(sb.ZEnD, sb.Adr3D, pend_rd_q));
    waw_s    = busy_s & addr_hit(sb.FRegWriteD, sb.RdD, pend_rd_q);
    struct_s = sb.DivStartD & (busy_s | (sb.DivStartE & ~sb.FlushE));

    div_write_s = 1'b0;
    case (state_q)
      FDIV_BUSY: div_write_s = sb.DivDone & ~sb.FRegWriteW;
      FDIV_HOLD: div_write_s = ~sb.FRegWriteW;
      default:   div_write_s = 1'b0;
    endcase

    // Reset masks every output so nothing leaks from stale state.
    sb.FPUStallD = (raw_s | waw_s | struct_s) & ~reset;
    sb.DivWriteW = div_write_s & ~reset;
    sb.DivResSel = (state_q == FDIV_HOLD) & ~reset;
    sb.DivRdW    = (busy_s & ~reset) ? pend_rd_q : 5'd0;
  end

endmodule

// File: doc/fdiv_scoreboard.md
FDIV_SCOREBOARD -- requirements
Module: fdivscoreboard

Interface
REQ-001 clk  input  1  Sole clock; all state updates on rising edge.
REQ-002 reset  input  1  Synchronous, active-high reset.
REQ-003 Adr1D, Adr2D, Adr3D  input  5 each  FP source register addresses of the decode-stage instruction.
REQ-004 XEnD, YEnD, ZEnD  input  1 each  Source operand X/Y/Z of the decode-stage instruction is used.
REQ-005 FRegWriteD  input  1  Decode-stage instruction writes the FP register file.
REQ-006 RdD  input  5  Destination of the decode-stage instruction.
REQ-007 DivStartD  input  1  Decode-stage instruction is an FP div/sqrt.
REQ-008 DivStartE  input  1  Execute-stage instruction is an FP div/sqrt issuing this cycle.
REQ-009 RdE  input  5  Destination of the execute-stage instruction.
REQ-010 FlushE  input  1  Execute-stage instruction is squashed this cycle.
REQ-011 DivDone  input  1  Div/sqrt unit presents its final result this cycle (one-cycle pulse).
REQ-012 FRegWriteW  input  1  Pipeline writeback stage owns the FP write port this cycle.
REQ-013 FPUStallD  output  1  Stall decode for a div/sqrt hazard.
REQ-014 DivWriteW  output  1  Div/sqrt result is written to the FP register file this cycle.
REQ-015 DivRdW  output  5  Destination address for the div/sqrt write.
REQ-016 DivResSel  output  1  Selects the held div/sqrt result (1) over the live unit output (0) for the write.

Function
REQ-017 A 2-bit FSM SHALL have states IDLE, BUSY and HOLD.
REQ-018 IDLE->BUSY SHALL occur when DivStartE & ~FlushE; PendRd SHALL latch RdE on the same edge.
REQ-019 In BUSY, if DivDone & ~FRegWriteW: DivWriteW=1, DivResSel=0, DivRdW=PendRd, next state IDLE.
REQ-020 In BUSY, if DivDone & FRegWriteW: DivWriteW=0, next state HOLD, result captured by the datapath.
REQ-021 In HOLD, if ~FRegWriteW: DivWriteW=1, DivResSel=1, next state IDLE; otherwise remain in HOLD.
REQ-022 The pipeline writeback SHALL always win the write port; the divider SHALL never write when FRegWriteW=1.
REQ-023 DivDone in IDLE or HOLD SHALL be ignored (protocol violation; no state change).
REQ-024 Busy = (state != IDLE).
REQ-025 RAW = Busy & ((XEnD & Adr1D==PendRd) | (YEnD & Adr2D==PendRd) | (ZEnD & Adr3D==PendRd)).
REQ-026 WAW = Busy & FRegWriteD & (RdD==PendRd).
REQ-027 Structural = DivStartD & (Busy | (DivStartE & ~FlushE)).
REQ-028 FPUStallD SHALL equal (RAW | WAW | Structural) & ~reset, combinationally, in the same cycle.
REQ-029 A RAW on the completing register SHALL be released in the cycle DivWriteW=1 (stall drops next cycle, value read via W bypass).
REQ-030 DivRdW SHALL equal PendRd whenever Busy; 0 in IDLE.
REQ-031 FlushE SHALL suppress only a same-cycle issue; an already BUSY/HOLD operation SHALL complete.

Reset
REQ-032 Reset SHALL force state IDLE and PendRd 0, abandoning any in-flight or held result.
REQ-033 While reset=1: FPUStallD=0, DivWriteW=0, DivResSel=0, DivRdW=0.
REQ-034 Reset SHALL take priority over DivStartE and DivDone in the same cycle.

Structure
REQ-035 The FSM state enum typedef SHALL reside in the shared FPU package.
REQ-036 No sub-module; a single module containing the FSM, PendRd register and hazard comparators.

Verification
REQ-037 Issue: DivStartE=1, RdE=5; next cycle Adr1D=5, XEnD=1 -> FPUStallD=1 until DivDone; DivDone with FRegWriteW=0 -> DivWriteW=1, DivRdW=5, stall 0 the next cycle.
REQ-038 Port conflict: BUSY Rd=7, DivDone with FRegWriteW=1 for 3 cycles -> HOLD, DivWriteW=0 for 3 cycles, then DivWriteW=1, DivResSel=1, DivRdW=7.
REQ-039 Flush: DivStartE=1, FlushE=1, RdE=9 -> remains IDLE; Adr1D=9 with XEnD=1 -> FPUStallD=0.
REQ-040 Structural/WAW: BUSY Rd=3; DivStartD=1 -> stall; FRegWriteD=1, RdD=3 -> stall; RdD=4 with no source match -> no stall.
REQ-041 Reset mid-operation: reset in BUSY Rd=2 -> next cycle IDLE, all outputs 0; later stray DivDone -> no write.
REQ-042 Back-to-back: DivStartE and DivStartD both 1 -> stall; completion then re-issue with RdE=1 -> PendRd=1 and a clean second write.
